// File: rtl/arith_seq_divider.sv
// -----------------------------------------------------------------------------
// arith_seq_divider
//
// Iterative signed divider. It produces one quotient bit per cycle using
// restoring shift-subtract on operand magnitudes, then applies the signs.
// The quotient truncates toward zero and the remainder takes the sign of the
// dividend. A start/busy/done handshake connects it to the ALU control
// sequencer.
//
// Compile-time option:
//   DIV_REMAINDER_EN  defined   : R carries the sign-corrected remainder.
//                     undefined : R is tied to 0. Q, the flags and the
//                                 latency are unchanged.
//
// Parameters:
//   N         operand/result width in bits (N >= 2)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request; sampled only while idle
//   A, B      signed dividend / divisor, captured on an accepted start
//   busy      high whenever the unit is not idle
//   done      one-cycle pulse; results are valid from this cycle on
//   Q, R      signed quotient / remainder
//   Zero      Q == 0
//   Overflow  A == -2^(N-1) and B == -1 (Q wraps to -2^(N-1))
//   DivZero   B == 0
//
// Latency: a normal operation raises done N+2 cycles after start is
// accepted. A divide by zero raises done in the following cycle.
// -----------------------------------------------------------------------------
module arith_seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         Zero,
  output logic         Overflow,
  output logic         DivZero
);

  localparam int             CW      = $clog2(N);
  localparam logic [CW-1:0]  LAST    = CW'(N - 1);
  localparam logic [N-1:0]   MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   ONE     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q;

  // Datapath state. dvd_q shifts the dividend magnitude out at the top and
  // collects quotient bits at the bottom, so it holds |Q| when CALC ends.
  logic [N-1:0]  dvd_q;
  logic [N-1:0]  bmag_q;
  logic [N-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q_q;
  logic          ovf_pend_q;

  // Registered outputs.
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  q_q;
  logic          zero_q;
  logic          ovf_q;
  logic          dz_q;

`ifdef DIV_REMAINDER_EN
  logic          sign_r_q;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_fix_d;
`endif

  // Combinational helpers.
  logic [N-1:0]  a_mag_d;
  logic [N-1:0]  b_mag_d;
  logic [N-1:0]  q_fix_d;
  logic [N:0]    shift_d;
  logic [N:0]    trial_d;

  // The magnitude of -2^(N-1) wraps back to the bit pattern 100..0. Read as
  // unsigned, that pattern is exactly 2^(N-1), so no extra bit is needed.
  //
  // The partial remainder is always smaller than |B| <= 2^(N-1), so it fits
  // in N bits. Only the shifted value and the trial difference need the
  // (N+1)-th bit.
  always_comb begin
    a_mag_d = A[N-1] ? (~A + ONE) : A;
    b_mag_d = B[N-1] ? (~B + ONE) : B;
    shift_d = {rem_q, dvd_q[N-1]};
    trial_d = shift_d - {1'b0, bmag_q};
    q_fix_d = sign_q_q ? (~dvd_q + ONE) : dvd_q;
`ifdef DIV_REMAINDER_EN
    r_fix_d = sign_r_q ? (~rem_q + ONE) : rem_q;
`endif
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  // All registers in one edge-triggered block then update together, so their
  // order inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears only the control state and the visible outputs.
      // The operand and partial-result registers are always reloaded on an
      // accepted start, so they are left without a reset.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dvd_q      <= a_mag_d;
            bmag_q     <= b_mag_d;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_q_q   <= A[N-1] ^ B[N-1];
            ovf_pend_q <= (A == MIN_VAL) && (B == '1);
`ifdef DIV_REMAINDER_EN
            sign_r_q   <= A[N-1];
`endif
            busy_q     <= 1'b1;
            if (B == '0) begin
              // Divide by zero skips the iteration and reports at once.
              q_q     <= '0;
              zero_q  <= 1'b1;
              ovf_q   <= 1'b0;
              dz_q    <= 1'b1;
`ifdef DIV_REMAINDER_EN
              r_q     <= A;
`endif
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          // Restoring step: keep the subtraction only when it does not
          // borrow. A borrow shows up as the top bit of the trial difference.
          if (!trial_d[N]) begin
            rem_q <= trial_d[N-1:0];
            dvd_q <= {dvd_q[N-2:0], 1'b1};
          end else begin
            rem_q <= shift_d[N-1:0];
            dvd_q <= {dvd_q[N-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          q_q     <= q_fix_d;
          zero_q  <= (q_fix_d == '0);
          ovf_q   <= ovf_pend_q;
          dz_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
          r_q     <= r_fix_d;
`endif
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Q        = q_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign DivZero  = dz_q;
`ifdef DIV_REMAINDER_EN
  assign R        = r_q;
`else
  assign R        = '0;
`endif

endmodule

// File: tb/tb_arith_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_arith_seq_divider
//
// Self-checking bench for arith_seq_divider with N=8. When an operation is
// issued, the expected result and latency are pushed onto a scoreboard queue.
// The entry is popped and compared when the DUT raises done. The expected
// values come from a behavioural model built on SystemVerilog signed / and %.
// -----------------------------------------------------------------------------
module tb_arith_seq_divider;

  localparam int N       = 8;
  localparam int MAXWAIT = 40;

`ifdef DIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         Zero;
  logic         Overflow;
  logic         DivZero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         zero;
    logic         ovf;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  arith_seq_divider #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .R        (R),
    .Zero     (Zero),
    .Overflow (Overflow),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  // Reference model for one operation, including its expected latency.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t                e;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      e.q    = '0;
      e.r    = REM_EN ? a : '0;
      e.zero = 1'b1;
      e.ovf  = 1'b0;
      e.dz   = 1'b1;
      e.lat  = 1;
    end else if (a == 8'h80 && b == 8'hFF) begin
      e.q    = 8'h80;
      e.r    = '0;
      e.zero = 1'b0;
      e.ovf  = 1'b1;
      e.dz   = 1'b0;
      e.lat  = N + 2;
    end else begin
      e.q    = sa / sb;
      e.r    = REM_EN ? (sa % sb) : '0;
      e.zero = (e.q == '0);
      e.ovf  = 1'b0;
      e.dz   = 1'b0;
      e.lat  = N + 2;
    end
    return e;
  endfunction

  // Waits (bounded) for done. lat counts rising edges since the start edge.
  task automatic wait_done(input int lat0, output bit seen, output int lat);
    lat  = lat0;
    seen = done;
    while (!seen && lat < MAXWAIT) begin
      @(posedge clk); #1;
      lat++;
      seen = done;
    end
  endtask

  // Scoreboard consumer: pops the oldest expectation and compares it.
  task automatic sb_compare(input string name, input bit seen, input int lat);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty when a result was checked", name);
      return;
    end
    e = sb_q.pop_front();
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL %s: done not seen within %0d cycles", name, MAXWAIT);
      return;
    end
    total++;
    if (lat !== e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    total++;
    if (Q !== e.q) begin
      bad++;
      $display("FAIL %s Q: got %h want %h", name, Q, e.q);
    end
    total++;
    if (R !== e.r) begin
      bad++;
      $display("FAIL %s R: got %h want %h", name, R, e.r);
    end
    total++;
    if ({Zero, Overflow, DivZero} !== {e.zero, e.ovf, e.dz}) begin
      bad++;
      $display("FAIL %s flags Z/O/DZ: got %b%b%b want %b%b%b", name,
               Zero, Overflow, DivZero, e.zero, e.ovf, e.dz);
    end
  endtask

  // Waits for idle, applies a one-cycle start and pushes the expectation.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int guard;
    guard = 0;
    while (busy && guard < MAXWAIT) begin
      @(posedge clk); #1;
      guard++;
    end
    A     = a;
    B     = b;
    start = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    bit seen;
    int lat;
    issue(a, b);
    wait_done(1, seen, lat);
    sb_compare(name, seen, lat);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({busy, done, Zero, Overflow, DivZero, Q, R} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b Z=%b O=%b DZ=%b Q=%h R=%h want all 0",
               busy, done, Zero, Overflow, DivZero, Q, R);
    end
  endtask

  task automatic test_basic;
    run_op("100/7", 8'd100, 8'd7);
    run_op("-100/7", 8'h9C, 8'd7);
    run_op("100/-7", 8'd100, 8'hF9);
    run_op("-100/-7", 8'h9C, 8'hF9);
    run_op("127/-128", 8'h7F, 8'h80);
    run_op("-128/-128", 8'h80, 8'h80);
    run_op("-1/1", 8'hFF, 8'h01);
    run_op("3/7", 8'd3, 8'd7);
    // busy must be high in the cycle right after acceptance.
    issue(8'd50, 8'd5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    begin
      bit seen;
      int lat;
      wait_done(1, seen, lat);
      sb_compare("50/5", seen, lat);
    end
  endtask

  task automatic test_overflow;
    run_op("ovf -128/-1", 8'h80, 8'hFF);
    run_op("-128/1", 8'h80, 8'h01);
  endtask

  task automatic test_div_zero;
    run_op("5/0", 8'd5, 8'd0);
    run_op("-128/0", 8'h80, 8'd0);
    run_op("3/7 after div0", 8'd3, 8'd7);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = N'($urandom);
      b = (i % 8 == 7) ? '0 : N'($urandom);
      run_op("random", a, b);
    end
  endtask

  task automatic test_busy_ignore;
    bit seen;
    int lat;
    int extra;
    issue(8'd100, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    A     = 8'd50;
    B     = 8'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A     = 8'hAA;
    B     = 8'h55;
    wait_done(4, seen, lat);
    sb_compare("ignored start", seen, lat);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++;
    if (extra !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored start extra: done pulses=%0d busy=%b want 0 and 0", extra, busy);
    end
  endtask

  task automatic test_mid_reset;
    int pulses;
    // Leave nonzero outputs behind first, so the reset clear is observable.
    run_op("pre-reset 100/7", 8'd100, 8'd7);
    issue(8'd100, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy, done, Zero, Overflow, DivZero, Q, R} !== '0) begin
      bad++;
      $display("FAIL mid reset: busy=%b done=%b Z=%b O=%b DZ=%b Q=%h R=%h want all 0",
               busy, done, Zero, Overflow, DivZero, Q, R);
    end
    // The discarded operation's expectation is dropped unchecked.
    void'(sb_q.pop_back());
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL mid reset done pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    bit   seen;
    int   lat;
    exp_t e;
    A     = 8'd100;
    B     = 8'd7;
    start = 1'b1;
    sb_q.push_back(model(8'd100, 8'd7));
    @(posedge clk); #1;
    wait_done(1, seen, lat);
    sb_compare("b2b first", seen, lat);
    // With start still high, the next operation is accepted at the first
    // idle cycle after DONE. That adds one edge to the normal latency as
    // measured from this done cycle.
    A = 8'd20;
    B = 8'hFD;
    e = model(8'd20, 8'hFD);
    e.lat = N + 3;
    sb_q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, seen, lat);
    sb_compare("b2b second", seen, lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_div_zero();
    test_random();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arith_seq_divider.md
Name: arith_seq_divider

Overview:
- Iterative signed divider: the inverse companion to the combinational add/subtract arithmetic path.
- Takes N-bit two's-complement dividend A and divisor B.
- Produces quotient Q (truncated toward zero) and remainder R (sign of dividend), plus Zero, Overflow and DivZero flags.
- One quotient bit per cycle using restoring shift-subtract; start/busy/done handshake toward the ALU control sequencer.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  N  signed dividend, captured on accepted start
- B  input  N  signed divisor, captured on accepted start
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; results valid from this cycle on
- Q  output  N  signed quotient
- R  output  N  signed remainder
- Zero  output  1  Q == 0
- Overflow  output  1  A == -2^(N-1) and B == -1
- DivZero  output  1  B == 0

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-division):
  - state <= IDLE.
  - busy, done, Q, R, Zero, Overflow and DivZero all <= 0.
  - Any in-flight operation is discarded; no done is issued for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 captures A and B, records sign_q = A[N-1]^B[N-1] and sign_r = A[N-1].
  - Loads |A| and |B| into N-bit unsigned registers. |-2^(N-1)| is represented as unsigned 2^(N-1).
  - Clears the partial remainder (N+1 bits) and the iteration counter.
  - If B == 0: go to DONE. Otherwise go to CALC.
- CALC, exactly N cycles:
  - Shift {rem, dvd} left by 1.
  - trial = rem - |B| (N+1 bits).
  - If trial is non-negative: rem <= trial and the quotient LSB <= 1; else the LSB <= 0.
  - The counter increments each cycle; after the N-th iteration go to FIX.
- FIX, 1 cycle:
  - Q <= sign_q ? -qmag : qmag, taken mod 2^N.
  - R <= sign_r ? -rem : rem.
  - Zero <= (Q result == 0).
  - Overflow <= (A == 100..0 && B == 11..1); Q is then the wrapped value 100..0.
  - DivZero <= 0.
  - Go to DONE.
- Divide by zero (IDLE -> DONE path):
  - Q <= 0, R <= A, DivZero <= 1, Zero <= 1, Overflow <= 0.
- DONE, 1 cycle: done=1, busy=1, then go to IDLE.
- Latency:
  - Normal: start accepted at edge k; done is high in the cycle after edge k+N+1, i.e. N+2 cycles after start.
  - B == 0: done is high in the cycle after edge k.
- Q, R and all flags hold their values from DONE until the next accepted start's FIX or DONE update.
- start while busy=1 is ignored; there is no queuing.
- start held high continuously: a new operation is accepted at the first IDLE cycle after DONE.
- A and B may change freely after acceptance.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined: R is computed with sign correction as above.
- Undefined:
  - The remainder sign-fix logic and R register are removed; R is driven constantly 0.
  - The partial remainder is still used internally; Q, the flags and the latency are unchanged.

Test Plan:
- N=8, A=100, B=7, start pulse -> done exactly 10 cycles later; Q=14, R=2, Zero=0, Overflow=0, DivZero=0.
- A=-100 (8'h9C), B=7 -> Q=8'hF2 (-14), R=8'hFE (-2); A=100, B=-7 -> Q=8'hF2, R=8'h02.
- A=8'h80, B=8'hFF -> Q=8'h80, R=0, Overflow=1; A=8'h80, B=1 -> Q=8'h80, Overflow=0.
- A=5, B=0 -> done 1 cycle after start; Q=0, R=5, DivZero=1, Zero=1. Then A=3, B=7 -> Q=0, R=3, Zero=1, DivZero=0.
- Start 100/7, pulse start with 50/5 at cycle 3 -> second start ignored; result is 14 r 2. Then rst at cycle 4 of a new division -> busy=0 and all outputs 0 next cycle; no done pulse.
- With DIV_REMAINDER_EN undefined, 100/7 -> Q=14, R=0, same latency.
